// File: rtl/hilo_controller.sv
// HI/LO register owner: sequences MULT/MULTU, DIV/DIVU, MTHI/MTLO and MFHI/MFLO from EX,
// running a fixed-latency multiply and handshaking with the external multi-cycle divider.
module hilo_controller #(
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_op_div,
  output logic        div_op_divu,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_stall
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;
  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO
  } op_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic [63:0] r_product, w_product_nxt, w_prod_s, w_prod_u;
  logic [3:0]  r_mul_cnt, w_mul_cnt_nxt;
  logic        r_div_neg, w_div_neg_nxt;
  logic        w_live, w_accept;
  op_t         w_op;

  assign w_op     = op_t'(op);
  assign w_live   = op_valid && !flush && !reset;
  assign w_accept = w_live && (r_state == IDLE);
  assign stall    = w_live && (r_state != IDLE);
  assign busy     = (r_state != IDLE);
  assign hi       = r_hi;
  assign lo       = r_lo;

  assign div_dividend = rs_data;
  assign div_divisor  = rt_data;

  assign w_prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign w_prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  always_comb begin
    w_state_nxt   = r_state;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_product_nxt = r_product;
    w_mul_cnt_nxt = r_mul_cnt;
    w_div_neg_nxt = r_div_neg;
    hilo_rdata    = '0;
    div_op_div    = 1'b0;
    div_op_divu   = 1'b0;

    // Flush drops whatever is pending; a divider run already launched is simply ignored.
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (w_op)
              OP_MULT, OP_MULTU: begin
                w_product_nxt = (w_op == OP_MULT) ? w_prod_s : w_prod_u;
                w_mul_cnt_nxt = MUL_LOAD;
                if (MUL_LATENCY == 1) {w_hi_nxt, w_lo_nxt} = w_product_nxt;
                else                  w_state_nxt = MUL_WAIT;
              end
              OP_DIV, OP_DIVU: begin
                if (rt_data == '0) begin
                  w_lo_nxt = '1;
                  w_hi_nxt = rs_data;
                end else begin
                  div_op_div    = (w_op == OP_DIV);
                  div_op_divu   = (w_op == OP_DIVU);
                  w_div_neg_nxt = (w_op == OP_DIV) && rs_data[31];
                  w_state_nxt   = DIV_WAIT;
                end
              end
              OP_MTHI: w_hi_nxt   = rs_data;
              OP_MTLO: w_lo_nxt   = rs_data;
              OP_MFHI: hilo_rdata = r_hi;
              OP_MFLO: hilo_rdata = r_lo;
            endcase
          end
        end
        MUL_WAIT: begin
          // Counter holds cycles left including this one; the write lands as it would reach zero.
          if (r_mul_cnt <= 4'd1) begin
            {w_hi_nxt, w_lo_nxt} = r_product;
            w_mul_cnt_nxt        = '0;
            w_state_nxt          = IDLE;
          end else begin
            w_mul_cnt_nxt = r_mul_cnt - 4'd1;
          end
        end
        DIV_WAIT: begin
          if (!div_stall) begin
            w_lo_nxt    = div_quotient;
            w_hi_nxt    = r_div_neg ? (32'd0 - div_remainder) : div_remainder;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_product <= '0;
      r_mul_cnt <= '0;
      r_div_neg <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_product <= w_product_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
      r_div_neg <= w_div_neg_nxt;
    end
  end

endmodule
